// File: rtl/min_order_sequencer_pkg.sv
// Shared constants and state encoding for the four-entry ordered emitter.
package min_order_sequencer_pkg;

   localparam int unsigned N_ENTRIES = 4;
   localparam int unsigned IDX_W     = 2;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StEmit = 1'b1
   } state_e;

endpackage

// File: rtl/masked_extreme_index.sv
// Picks the smallest (desc=0) or largest (desc=1) unmasked entry of four; ties go to the
// lowest index. Also flags when exactly one entry remains unmasked.
module masked_extreme_index
   import min_order_sequencer_pkg::*;
#(
   parameter int unsigned W = 3
) (
   input  logic [N_ENTRIES*W-1:0] vals,
   input  logic [N_ENTRIES-1:0]   mask,
   input  logic                   desc,
   output logic [IDX_W-1:0]       idx,
   output logic                   one_left
);

   // Right operand always carries the higher index, so it wins only on a strict improvement.
   function automatic logic take_right(input logic [W-1:0] lv, input logic lok,
                                       input logic [W-1:0] rv, input logic rok,
                                       input logic dsc);
      if (!rok) return 1'b0;
      if (!lok) return 1'b1;
      return dsc ? (rv > lv) : (rv < lv);
   endfunction

   logic [W-1:0]       v0, v1, v2, v3;
   logic               ok0, ok1, ok2, ok3;
   logic [W-1:0]       lo_val, hi_val;
   logic [IDX_W-1:0]   lo_idx, hi_idx;
   logic               lo_ok, hi_ok;
   logic [N_ENTRIES-1:0] free;

   assign v0  = vals[0*W +: W];
   assign v1  = vals[1*W +: W];
   assign v2  = vals[2*W +: W];
   assign v3  = vals[3*W +: W];
   assign ok0 = ~mask[0];
   assign ok1 = ~mask[1];
   assign ok2 = ~mask[2];
   assign ok3 = ~mask[3];

   always_comb begin
      lo_ok = ok0 | ok1;
      if (take_right(v0, ok0, v1, ok1, desc)) begin
         lo_val = v1;
         lo_idx = 2'd1;
      end else begin
         lo_val = v0;
         lo_idx = 2'd0;
      end

      hi_ok = ok2 | ok3;
      if (take_right(v2, ok2, v3, ok3, desc)) begin
         hi_val = v3;
         hi_idx = 2'd3;
      end else begin
         hi_val = v2;
         hi_idx = 2'd2;
      end

      idx = take_right(lo_val, lo_ok, hi_val, hi_ok, desc) ? hi_idx : lo_idx;
   end

   assign free     = ~mask;
   assign one_left = (free != '0) && ((free & (free - 4'd1)) == '0);

endmodule

// File: rtl/min_order_sequencer.sv
// Loads a batch of four values, then streams them out in ascending or descending order,
// one per out handshake, tagging each with its original index.
module min_order_sequencer
   import min_order_sequencer_pkg::*;
#(
   parameter int unsigned W = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N_ENTRIES*W-1:0] in_data,
   input  logic                   in_desc,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [W-1:0]           out_data,
   output logic [IDX_W-1:0]       out_idx,
   output logic                   out_last,
   output logic                   busy
);

   state_e                 state_q, state_d;
   logic [N_ENTRIES*W-1:0] vals_q, vals_d;
   logic                   desc_q, desc_d;
   logic [N_ENTRIES-1:0]   taken_q, taken_d;

   logic [IDX_W-1:0]       sel;
   logic                   one_left;

   masked_extreme_index #(
      .W (W)
   ) u_pick (
      .vals     (vals_q),
      .mask     (taken_q),
      .desc     (desc_q),
      .idx      (sel),
      .one_left (one_left)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         vals_q  <= '0;
         desc_q  <= 1'b0;
         taken_q <= '0;
      end else begin
         state_q <= state_d;
         vals_q  <= vals_d;
         desc_q  <= desc_d;
         taken_q <= taken_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      vals_d    = vals_q;
      desc_d    = desc_q;
      taken_d   = taken_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_data  = '0;
      out_idx   = '0;
      out_last  = 1'b0;
      busy      = 1'b0;

      unique case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) begin
               vals_d  = in_data;
               desc_d  = in_desc;
               taken_d = '0;
               state_d = StEmit;
            end
         end
         StEmit: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_data  = vals_q[sel*W +: W];
            out_idx   = sel;
            out_last  = one_left;
            if (out_ready) begin
               taken_d[sel] = 1'b1;
               if (one_left) state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_min_order_sequencer.sv
// Directed bench for min_order_sequencer: hand-computed emit orders per batch.
module tb_min_order_sequencer;

   localparam int W = 3;

   logic           clk;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [4*W-1:0] in_data;
   logic           in_desc;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   out_data;
   logic [1:0]     out_idx;
   logic           out_last;
   logic           busy;

   int errors = 0;
   int checks = 0;

   min_order_sequencer #(
      .W (W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_desc   (in_desc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Observed item packed as {valid, last, idx, data}.
   function automatic logic [31:0] item(input logic [W-1:0] d, input logic [1:0] i,
                                        input logic l);
      return {25'd0, 1'b1, l, i, d};
   endfunction

   task automatic expect_item(input string tag, input logic [W-1:0] d, input logic [1:0] i,
                              input logic l);
      check(tag, {25'd0, out_valid, out_last, out_idx, out_data}, item(d, i, l));
   endtask

   task automatic load(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] d, input logic dsc);
      in_data  = {d, c, b, a};
      in_desc  = dsc;
      in_valid = 1'b1;
      check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
   endtask

   // Consumes one item with out_ready=1 after checking it.
   task automatic take(input string tag, input logic [W-1:0] d, input logic [1:0] i,
                       input logic l);
      out_ready = 1'b1;
      expect_item(tag, d, i, l);
      step();
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_idle"}, {28'd0, out_valid, out_last, busy, in_ready}, 32'b0001);
   endtask

   logic [6:0] pattern;
   logic [W-1:0] t4_d [4];
   logic [1:0]   t4_i [4];
   int k;

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_desc   = 1'b0;
      out_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      check_idle("reset");
      check("reset_data", {27'd0, out_idx, out_data}, 32'd0);

      // Ascending, distinct values
      load("t1", 3'd7, 3'd3, 3'd2, 3'd1, 1'b0);
      take("t1_0", 3'd1, 2'd3, 1'b0);
      take("t1_1", 3'd2, 2'd2, 1'b0);
      take("t1_2", 3'd3, 2'd1, 1'b0);
      take("t1_3", 3'd7, 2'd0, 1'b1);
      check_idle("t1_end");

      // All equal: index order
      load("t2", 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
      take("t2_0", 3'd0, 2'd0, 1'b0);
      take("t2_1", 3'd0, 2'd1, 1'b0);
      take("t2_2", 3'd0, 2'd2, 1'b0);
      take("t2_3", 3'd0, 2'd3, 1'b1);
      check_idle("t2_end");

      // Descending with ties
      load("t3", 3'd6, 3'd7, 3'd5, 3'd7, 1'b1);
      take("t3_0", 3'd7, 2'd1, 1'b0);
      take("t3_1", 3'd7, 2'd3, 1'b0);
      take("t3_2", 3'd6, 2'd0, 1'b0);
      take("t3_3", 3'd5, 2'd2, 1'b1);
      check_idle("t3_end");

      // Backpressure: item must hold across out_ready=0 cycles
      t4_d[0] = 3'd0; t4_i[0] = 2'd2;
      t4_d[1] = 3'd1; t4_i[1] = 2'd1;
      t4_d[2] = 3'd3; t4_i[2] = 2'd3;
      t4_d[3] = 3'd4; t4_i[3] = 2'd0;
      pattern = 7'b1011001; // bit 0 first: 1,0,0,1,1,0,1
      load("t4", 3'd4, 3'd1, 3'd0, 3'd3, 1'b0);
      k = 0;
      for (int c = 0; c < 7; c++) begin
         out_ready = pattern[c];
         if (k < 4) expect_item($sformatf("t4_c%0d", c), t4_d[k], t4_i[k], k == 3);
         else check($sformatf("t4_c%0d_extra", c), {31'd0, out_valid}, 32'd0);
         step();
         if (pattern[c] && k < 4) k++;
      end
      check("t4_count", k, 32'd4);
      check_idle("t4_end");

      // Load attempt during EMIT is ignored
      load("t5", 3'd5, 3'd1, 3'd7, 3'd4, 1'b0);
      take("t5_0", 3'd1, 2'd1, 1'b0);
      take("t5_1", 3'd4, 2'd3, 1'b0);
      in_data  = {3'd1, 3'd6, 3'd3, 3'd2};
      in_desc  = 1'b0;
      in_valid = 1'b1;
      check("t5_busy_ready", {30'd0, in_ready, busy}, 32'b01);
      take("t5_2", 3'd5, 2'd0, 1'b0);
      take("t5_3", 3'd7, 2'd2, 1'b1);
      out_ready = 1'b0;
      check_idle("t5_end");
      step();
      in_valid = 1'b0;
      take("t5n_0", 3'd1, 2'd3, 1'b0);
      take("t5n_1", 3'd2, 2'd0, 1'b0);
      take("t5n_2", 3'd3, 2'd1, 1'b0);
      take("t5n_3", 3'd6, 2'd2, 1'b1);
      check_idle("t5n_end");

      // Reset mid-EMIT discards the rest
      load("t6", 3'd3, 3'd2, 3'd4, 3'd6, 1'b0);
      take("t6_0", 3'd2, 2'd1, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_idle("t6_rst");
      step();
      check_idle("t6_rst2");
      load("t6n", 3'd2, 3'd3, 3'd6, 3'd1, 1'b0);
      take("t6n_0", 3'd1, 2'd3, 1'b0);
      take("t6n_1", 3'd2, 2'd0, 1'b0);
      take("t6n_2", 3'd3, 2'd1, 1'b0);
      take("t6n_3", 3'd6, 2'd2, 1'b1);
      check_idle("t6n_end");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
